lsu_exec: RTL and testbench

// - Execute stage of the LSU slot: consumes decoded load/store fields, computes EA = base + sext(imm),

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/lsu_exec.sv | 149 ++++++++++++++
 tb/tb_lsu_exec.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and alignment helpers for the LSU execute slot.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } lsu_state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Size code 2'b11 behaves as a word everywhere.
    function automatic logic [1:0] lsu_force_align(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            LSU_B:   return lo;
            LSU_H:   return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            LSU_B:   return 1'b0;
            LSU_H:   return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated data, and load extract + extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_ea_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_ea_lo,
    input  logic        i_ld_zext,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            LSU_B: begin
                o_be    = 4'b0001 << i_ea_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            LSU_H: begin
                o_be    = 4'b0011 << {i_ea_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = i_rdata >> {i_ld_ea_lo, 3'b000};

    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_size)
            LSU_B:   o_ld_data = {{24{~i_ld_zext & w_shifted[7]}}, w_shifted[7:0]};
            LSU_H:   o_ld_data = {{16{~i_ld_zext & w_shifted[15]}}, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_exec.sv
// LSU execute stage: EA generation, single outstanding memory access, load writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module lsu_exec
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RSP_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic            op_is_load,
    input  logic            op_zero_ext,
    input  logic [1:0]      op_size,
    input  logic [4:0]      op_rd,
    input  logic [XLEN-1:0] op_base,
    input  logic [XLEN-1:0] op_wdata,
    input  logic [11:0]     op_imm,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [3:0]      mem_req_be,
    output logic [XLEN-1:0] mem_req_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            lsu_err
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    lsu_state_e      r_state;
    logic [XLEN-1:0] r_addr, r_wdata, r_wb_data;
    logic [3:0]      r_be;
    logic            r_we, r_zext, r_wb_valid, r_err;
    logic [1:0]      r_size, r_ea_lo;
    logic [4:0]      r_rd, r_wb_rd;
    logic [31:0]     r_cnt;

    logic [XLEN-1:0] w_ea, w_wdata, w_ld_data;
    logic [1:0]      w_ea_lo;
    logic [3:0]      w_be;
    logic            w_mis;

    assign w_ea  = op_base + {{(XLEN-12){op_imm[11]}}, op_imm};
    assign w_mis = lsu_misaligned(op_size, w_ea[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_ea_lo = w_ea[1:0];
`else
    assign w_ea_lo = lsu_force_align(op_size, w_ea[1:0]);
`endif

    lsu_align u_align (
        .i_size     (op_size),
        .i_ea_lo    (w_ea_lo),
        .i_wdata    (op_wdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .i_ld_size  (r_size),
        .i_ld_ea_lo (r_ea_lo),
        .i_ld_zext  (r_zext),
        .i_rdata    (mem_rsp_rdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_zext     <= 1'b0;
            r_size     <= '0;
            r_ea_lo    <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (op_valid) begin
                        if (TRAP && w_mis) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= REQ;
                            r_addr  <= {w_ea[XLEN-1:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_we    <= ~op_is_load;
                            r_size  <= op_size;
                            r_ea_lo <= w_ea_lo;
                            r_zext  <= op_zero_ext;
                            r_rd    <= op_rd;
                            r_cnt   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) r_state <= r_we ? IDLE : RESP;
                end
                RESP: begin
                    if (mem_rsp_valid) begin
                        r_state <= IDLE;
                        // x0 loads still complete the bus access but never write back
                        if (r_rd != 5'd0) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= w_ld_data;
                        end
                    end else if (RSP_TIMEOUT > 0 && r_cnt == 32'(RSP_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign op_ready      = (r_state == IDLE);
    assign stall         = (r_state != IDLE);
    assign mem_req_valid = (r_state == REQ);
    assign mem_req_we    = r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_be    = r_be;
    assign mem_req_wdata = r_wdata;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign lsu_err       = r_err;

endmodule

// File: tb/tb_lsu_exec.sv
// Directed + random bench for lsu_exec against an arithmetic reference model (RSP_TIMEOUT=4).
module tb_lsu_exec;

    localparam int TO = 4;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        op_valid = 1'b0, op_ready, op_is_load = 1'b0, op_zero_ext = 1'b0;
    logic [1:0]  op_size = '0;
    logic [4:0]  op_rd = '0;
    logic [31:0] op_base = '0, op_wdata = '0;
    logic [11:0] op_imm = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        wb_valid, stall, lsu_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0, n_fail = 0;

    lsu_exec #(.XLEN(32), .RSP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_is_load(op_is_load),
        .op_zero_ext(op_zero_ext), .op_size(op_size), .op_rd(op_rd),
        .op_base(op_base), .op_wdata(op_wdata), .op_imm(op_imm),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be),
        .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall), .lsu_err(lsu_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Present one op at the current negedge; returns at the negedge after the accept edge.
    task automatic accept_op(input bit ld, input bit zx, input logic [1:0] sz, input logic [4:0] rd,
                             input logic [31:0] base, input logic [31:0] wd, input logic [11:0] imm);
        check("op_ready_before_accept", 32'(op_ready), 32'd1);
        op_valid = 1'b1; op_is_load = ld; op_zero_ext = zx; op_size = sz; op_rd = rd;
        op_base = base; op_wdata = wd; op_imm = imm;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
    endtask

    // Full transaction with reference model. rsp_dly < 0 means memory never answers.
    task automatic run_op(input string nm, input bit ld, input bit zx, input logic [1:0] sz,
                          input logic [4:0] rd, input logic [31:0] base, input logic [31:0] wd,
                          input logic [11:0] imm, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rdata);
        int          nbytes, simm;
        logic [31:0] ea, ea_al, e_addr, e_wd, e_ld;
        logic [3:0]  e_be;
        longint      v, range;
        bit          mis;

        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        simm   = imm[11] ? int'(imm) - 4096 : int'(imm);
        ea     = base + 32'(simm);
        mis    = (ea % nbytes) != 0;
        ea_al  = ea - (ea % nbytes);
        e_addr = ea - (ea % 4);
        e_be   = 4'(((1 << nbytes) - 1) << (ea_al % 4));
        e_wd   = (nbytes == 1) ? wd[7:0] * 32'h0101_0101 :
                 (nbytes == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        v      = longint'(rdata >> (8 * (ea_al % 4)));
        range  = longint'(1) << (8 * nbytes);
        v      = v % range;
        if (!zx && v >= range / 2) v = v - range;
        e_ld   = 32'(v);

        accept_op(ld, zx, sz, rd, base, wd, imm);
        if (TRAP && mis) begin
            check({nm, "_trap_err"}, 32'(lsu_err), 32'd1);
            check({nm, "_trap_noreq"}, 32'(mem_req_valid), 32'd0);
            check({nm, "_trap_stall"}, 32'(stall), 32'd0);
            @(negedge clk);
            check({nm, "_trap_err_pulse"}, 32'(lsu_err), 32'd0);
            check({nm, "_trap_nowb"}, 32'(wb_valid), 32'd0);
            return;
        end
        check({nm, "_req_valid"}, 32'(mem_req_valid), 32'd1);
        check({nm, "_op_ready_busy"}, 32'(op_ready), 32'd0);
        check({nm, "_stall"}, 32'(stall), 32'd1);
        check({nm, "_addr"}, mem_req_addr, e_addr);
        check({nm, "_be"}, 32'(mem_req_be), 32'(e_be));
        check({nm, "_we"}, 32'(mem_req_we), 32'(!ld));
        if (!ld) check({nm, "_wdata"}, mem_req_wdata, e_wd);
        check({nm, "_err_none"}, 32'(lsu_err), 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            mem_rsp_valid = (i == 0);  // stray response while in REQ must be ignored
            mem_rsp_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            check({nm, "_hold_valid"}, 32'(mem_req_valid), 32'd1);
            check({nm, "_hold_addr"}, mem_req_addr, e_addr);
            check({nm, "_hold_be"}, 32'(mem_req_be), 32'(e_be));
            check({nm, "_hold_nowb"}, 32'(wb_valid), 32'd0);
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        if (!ld) begin
            check({nm, "_st_done_stall"}, 32'(stall), 32'd0);
            check({nm, "_st_done_ready"}, 32'(op_ready), 32'd1);
            check({nm, "_st_nowb"}, 32'(wb_valid), 32'd0);
            return;
        end
        check({nm, "_resp_stall"}, 32'(stall), 32'd1);
        check({nm, "_resp_noreq"}, 32'(mem_req_valid), 32'd0);
        if (rsp_dly < 0) begin
            for (int k = 1; k <= TO; k++) begin
                @(negedge clk);
                check({nm, "_to_err"}, 32'(lsu_err), (k == TO) ? 32'd1 : 32'd0);
                check({nm, "_to_stall"}, 32'(stall), (k == TO) ? 32'd0 : 32'd1);
                check({nm, "_to_nowb"}, 32'(wb_valid), 32'd0);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            @(negedge clk);
            check({nm, "_late_nowb"}, 32'(wb_valid), 32'd0);
            check({nm, "_late_err"}, 32'(lsu_err), 32'd0);
            check({nm, "_late_stall"}, 32'(stall), 32'd0);
            return;
        end
        for (int i = 0; i < rsp_dly; i++) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check({nm, "_wb_valid"}, 32'(wb_valid), 32'(rd != 5'd0));
        if (rd != 5'd0) begin
            check({nm, "_wb_rd"}, 32'(wb_rd), 32'(rd));
            check({nm, "_wb_data"}, wb_data, e_ld);
        end
        check({nm, "_ld_done_stall"}, 32'(stall), 32'd0);
        check({nm, "_ld_done_ready"}, 32'(op_ready), 32'd1);
        @(negedge clk);
        check({nm, "_wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_err", 32'(lsu_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_addr", mem_req_addr, 32'd0);
        check("rst_be", 32'(mem_req_be), 32'd0);
        check("rst_wdata", mem_req_wdata, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);

        run_op("sw",   1'b0, 1'b0, 2'b10, 5'd0, 32'h1000, 32'hDEADBEEF, 12'h004, 3, 0, 32'h0);
        run_op("lb",   1'b1, 1'b0, 2'b00, 5'd5, 32'h2003, 32'h0, 12'h000, 0, 0, 32'h80AA5511);
        run_op("lbu",  1'b1, 1'b1, 2'b00, 5'd6, 32'h2003, 32'h0, 12'h000, 0, 0, 32'h80AA5511);
        run_op("lh",   1'b1, 1'b0, 2'b01, 5'd7, 32'h2002, 32'h0, 12'h000, 1, 1, 32'h80AA5511);
        run_op("sh",   1'b0, 1'b0, 2'b01, 5'd0, 32'h0100, 32'h00001234, 12'hFFE, 0, 0, 32'h0);
        run_op("lwmis",1'b1, 1'b0, 2'b10, 5'd8, 32'h1001, 32'h0, 12'h000, 0, 0, 32'h1234_5678);
        run_op("wrap", 1'b0, 1'b0, 2'b00, 5'd0, 32'hFFFF_FFFE, 32'h0000_00A5, 12'h003, 0, 0, 32'h0);
        run_op("lwsz3",1'b1, 1'b0, 2'b11, 5'd9, 32'h3000, 32'h0, 12'h008, 0, 2, 32'hCAFE_F00D);
        run_op("ldx0", 1'b1, 1'b0, 2'b10, 5'd0, 32'h4000, 32'h0, 12'h000, 0, 0, 32'h1111_2222);
        run_op("ldto", 1'b1, 1'b0, 2'b10, 5'd3, 32'h5000, 32'h0, 12'h000, 0, -1, 32'h3333_4444);

        // Reset while waiting for a load response.
        accept_op(1'b1, 1'b0, 2'b10, 5'd4, 32'h6000, 32'h0, 12'h000);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("rstmid_in_resp", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_req", 32'(mem_req_valid), 32'd0);
        check("rstmid_wb", 32'(wb_valid), 32'd0);
        check("rstmid_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("rstmid_rsp_dropped", 32'(wb_valid), 32'd0);
        check("rstmid_noreq", 32'(mem_req_valid), 32'd0);
        run_op("post_rst", 1'b1, 1'b0, 2'b01, 5'd10, 32'h7000, 32'h0, 12'h002, 0, 0, 32'h8001_7FFF);

        for (int n = 0; n < 40; n++) begin
            run_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                   12'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
